// File: rtl/hm01b0_frame_packetizer.sv
// Frames HM01B0 pixel bytes into a byte stream for the SPRAM UART buffer:
// 3-byte header (SYNC0, SYNC1, frame_count), pixels, 2-byte trailer
// (checksum, status).
// Ports:
//   clock, reset_n        - system clock, async active-low reset
//   pix_data/pix_valid    - pixel byte and its one-cycle strobe
//   line_valid            - camera LVLD, synchronised
//   frame_valid           - camera FVLD, synchronised
//   enable                - capture enable, sampled at frame start only
//   data_out/_valid       - byte stream to the buffer, one byte per cycle max
//   frame_count           - frames emitted, mod 256
//   frame_error           - status of last emitted trailer was non-zero
//   busy                  - block is not idle
module hm01b0_frame_packetizer #(
    parameter int unsigned FRAME_WIDTH  = 324,
    parameter int unsigned FRAME_HEIGHT = 244,
    parameter logic [7:0]  SYNC0        = 8'hA5,
    parameter logic [7:0]  SYNC1        = 8'h5A
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    input  logic       line_valid,
    input  logic       frame_valid,
    input  logic       enable,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    output logic [7:0] frame_count,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned PHASE_W = 2;

    localparam logic [CNT_W-1:0] COL_LIMIT = CNT_W'(FRAME_WIDTH);
    localparam logic [CNT_W-1:0] ROW_LIMIT = CNT_W'(FRAME_HEIGHT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_HEADER,
        S_PIXELS,
        S_TRAILER
    } state_t;

    state_t             state, state_nxt;
    logic [PHASE_W-1:0] phase, phase_nxt;
    logic               fv_q, lv_q;
    logic               fv_fell, fv_fell_nxt;
    logic               overrun, overrun_nxt;
    logic               col_err, col_err_nxt;
    logic               row_ovf, row_ovf_nxt;
    logic [CNT_W-1:0]   row, row_nxt;
    logic [CNT_W-1:0]   col, col_nxt;
    logic [7:0]         checksum, checksum_nxt;
    logic [7:0]         dout_nxt;
    logic               dvalid_nxt;
    logic [7:0]         fcount_nxt;
    logic               ferr_nxt;

    logic       fv_rise_c, fv_fall_c, lv_fall_c;
    logic       row_err_c;
    logic [7:0] status_c;

    // Edge detection against the registered strobes
    assign fv_rise_c = frame_valid & ~fv_q;
    assign fv_fall_c = ~frame_valid & fv_q;
    assign lv_fall_c = ~line_valid & lv_q;

    // Pixels landing beyond the last row also flag the row error
    assign row_err_c = (row != ROW_LIMIT) | row_ovf;
    assign status_c  = {row_err_c, col_err, overrun, 5'b0};

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        fv_fell_nxt  = fv_fell;
        overrun_nxt  = overrun;
        col_err_nxt  = col_err;
        row_ovf_nxt  = row_ovf;
        row_nxt      = row;
        col_nxt      = col;
        checksum_nxt = checksum;
        dout_nxt     = data_out;
        dvalid_nxt   = 1'b0;
        fcount_nxt   = frame_count;
        ferr_nxt     = frame_error;

        case (state)
            S_IDLE: begin
                if (fv_rise_c) begin
                    state_nxt = enable ? S_HEADER : S_SKIP;
                    phase_nxt = '0;
                end
            end

            S_SKIP: begin
                if (fv_fall_c) begin
                    state_nxt = S_IDLE;
                end
            end

            S_HEADER: begin
                dvalid_nxt = 1'b1;
                case (phase)
                    PHASE_W'(0): dout_nxt = SYNC0;
                    PHASE_W'(1): dout_nxt = SYNC1;
                    default:     dout_nxt = frame_count;
                endcase
                if (pix_valid) begin
                    overrun_nxt = 1'b1;
                end
                if (fv_fall_c) begin
                    fv_fell_nxt = 1'b1;
                end
                if (phase == PHASE_W'(2)) begin
                    // A frame that ended during the header goes straight to the trailer
                    state_nxt   = (fv_fell || fv_fall_c) ? S_TRAILER : S_PIXELS;
                    phase_nxt   = '0;
                    fv_fell_nxt = 1'b0;
                end else begin
                    phase_nxt = phase + PHASE_W'(1);
                end
            end

            S_PIXELS: begin
                if (pix_valid && line_valid) begin
                    if (col != CNT_MAX) begin
                        col_nxt = col + CNT_W'(1);
                    end
                    if (col >= COL_LIMIT) begin
                        col_err_nxt = 1'b1;
                    end
                    if (row >= ROW_LIMIT) begin
                        row_ovf_nxt = 1'b1;
                    end
                    if ((col < COL_LIMIT) && (row < ROW_LIMIT)) begin
                        checksum_nxt = checksum + pix_data;
                        dout_nxt     = pix_data;
                        dvalid_nxt   = 1'b1;
                    end
                end
                // Accept needs line_valid high, so it never coincides with lv_fall
                if (lv_fall_c) begin
                    if (col != COL_LIMIT) begin
                        col_err_nxt = 1'b1;
                    end
                    if (row != CNT_MAX) begin
                        row_nxt = row + CNT_W'(1);
                    end
                    col_nxt = '0;
                end
                if (fv_fall_c) begin
                    state_nxt = S_TRAILER;
                    phase_nxt = '0;
                end
            end

            S_TRAILER: begin
                dvalid_nxt = 1'b1;
                if (phase == PHASE_W'(0)) begin
                    dout_nxt  = checksum;
                    phase_nxt = PHASE_W'(1);
                end else begin
                    dout_nxt     = status_c;
                    ferr_nxt     = |status_c;
                    fcount_nxt   = frame_count + 8'd1;
                    checksum_nxt = '0;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    overrun_nxt  = 1'b0;
                    col_err_nxt  = 1'b0;
                    row_ovf_nxt  = 1'b0;
                    phase_nxt    = '0;
                    // frame_valid high here means a frame began during the trailer
                    state_nxt    = frame_valid ? S_SKIP : S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            phase          <= '0;
            fv_q           <= 1'b1;
            lv_q           <= 1'b1;
            fv_fell        <= 1'b0;
            overrun        <= 1'b0;
            col_err        <= 1'b0;
            row_ovf        <= 1'b0;
            row            <= '0;
            col            <= '0;
            checksum       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_count    <= '0;
            frame_error    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            phase          <= phase_nxt;
            fv_q           <= frame_valid;
            lv_q           <= line_valid;
            fv_fell        <= fv_fell_nxt;
            overrun        <= overrun_nxt;
            col_err        <= col_err_nxt;
            row_ovf        <= row_ovf_nxt;
            row            <= row_nxt;
            col            <= col_nxt;
            checksum       <= checksum_nxt;
            data_out       <= dout_nxt;
            data_out_valid <= dvalid_nxt;
            frame_count    <= fcount_nxt;
            frame_error    <= ferr_nxt;
            busy           <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_hm01b0_frame_packetizer.sv
// Bench for hm01b0_frame_packetizer with a small frame geometry (4x3).
// Frames are described as lines of pixel bytes; the expected byte stream is
// derived from that description and compared with the captured output.
module tb_hm01b0_frame_packetizer;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       line_valid;
    logic       frame_valid;
    logic       enable;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic [7:0] frame_count;
    logic       frame_error;
    logic       busy;

    hm01b0_frame_packetizer #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .SYNC0       (8'hA5),
        .SYNC1       (8'h5A)
    ) dut (
        .clock         (clk),
        .reset_n       (reset_n),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .line_valid    (line_valid),
        .frame_valid   (frame_valid),
        .enable        (enable),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .frame_count   (frame_count),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_count = 8'd0;
    logic       exp_err   = 1'b0;

    // Frame description
    int         n_lines;
    int         line_len[0:7];
    logic [7:0] pix[0:7][0:7];

    // Capture every emitted byte away from the active edge
    always @(negedge clk) begin
        if (data_out_valid) got_q.push_back(data_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_stream(input string tag);
        int n;
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(frame_count), 32'(exp_count));
        check({tag, "_ferr"},  32'(frame_error), 32'(exp_err));
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // Reference: header, in-bounds pixels, sum, status derived from the frame shape
    task automatic expect_frame(input bit ovr);
        logic [7:0] sum;
        logic       c_err;
        logic [7:0] status;
        sum   = 8'd0;
        c_err = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(exp_count);
        for (int r = 0; r < n_lines; r++) begin
            if (line_len[r] != W) c_err = 1'b1;
            for (int c = 0; c < line_len[r]; c++) begin
                if (c < W && r < H) begin
                    exp_q.push_back(pix[r][c]);
                    sum = sum + pix[r][c];
                end
            end
        end
        status = {(n_lines != H), c_err, ovr, 5'b0};
        exp_q.push_back(sum);
        exp_q.push_back(status);
        exp_err   = (status != 8'd0);
        exp_count = exp_count + 8'd1;
    endtask

    task automatic set_seq(input logic [7:0] start, input bit all_ff);
        logic [7:0] v;
        v = start;
        n_lines = H;
        for (int r = 0; r < H; r++) begin
            line_len[r] = W;
            for (int c = 0; c < W; c++) begin
                pix[r][c] = all_ff ? 8'hFF : v;
                v = v + 8'd1;
            end
        end
    endtask

    task automatic send_frame(input bit en, input bit ovr, input bit flip, input int post_idle);
        frame_valid = 1'b1;
        enable      = en;
        tick();
        tick();
        if (ovr) begin
            pix_valid = 1'b1;
            pix_data  = 8'h33;
        end
        tick();
        pix_valid = 1'b0;
        tick();
        if (flip) enable = !en;
        for (int r = 0; r < n_lines; r++) begin
            line_valid = 1'b1;
            for (int c = 0; c < line_len[r]; c++) begin
                if ($urandom_range(0, 2) == 0) tick();
                pix_valid = 1'b1;
                pix_data  = pix[r][c];
                tick();
                pix_valid = 1'b0;
                pix_data  = 8'($urandom_range(0, 255));
            end
            line_valid = 1'b0;
            tick();
            if ($urandom_range(0, 1) == 1) tick();
        end
        frame_valid = 1'b0;
        tick();
        repeat (post_idle) tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        pix_data    = 8'd0;
        pix_valid   = 1'b0;
        line_valid  = 1'b0;
        frame_valid = 1'b0;
        enable      = 1'b0;
        repeat (3) tick();
        check("rst_dout",   32'(data_out), 32'd0);
        check("rst_dvalid", 32'(data_out_valid), 32'd0);
        check("rst_count",  32'(frame_count), 32'd0);
        check("rst_ferr",   32'(frame_error), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();
        got_q.delete();

        // Basic 4x3 frame, pixels 01..0C
        set_seq(8'h01, 1'b0);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0, 1'b0, 4);
        check_stream("t1");
        check_status("t1");

        // Row 1 carries a fifth pixel that must be dropped
        set_seq(8'h01, 1'b0);
        line_len[1] = 5;
        pix[1][4]   = 8'hEE;
        for (int c = 0; c < 4; c++) pix[1][c] = 8'(5 + c);
        for (int c = 0; c < 4; c++) pix[2][c] = 8'(9 + c);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0, 1'b0, 4);
        check_stream("t2");
        check_status("t2");

        // Disabled at frame start, enable raised mid-frame: nothing emitted
        set_seq(8'h10, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 4);
        check_stream("t3");
        check_status("t3");
        set_seq(8'h20, 1'b0);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0, 1'b0, 4);
        check_stream("t3b");
        check_status("t3b");

        // Pixel strobe during the header is an overrun
        set_seq(8'h40, 1'b0);
        expect_frame(1'b1);
        send_frame(1'b1, 1'b1, 1'b0, 4);
        check_stream("t4");
        check_status("t4");

        // All-FF checksum wraps; two frames back to back
        set_seq(8'h00, 1'b1);
        expect_frame(1'b0);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0, 1'b0, 2);
        send_frame(1'b1, 1'b0, 1'b1, 4);
        check_stream("t6");
        check_status("t6");

        // A frame starting during the trailer is ignored
        set_seq(8'h60, 1'b0);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0, 1'b0, 1);
        send_frame(1'b1, 1'b0, 1'b0, 4);
        check_stream("t7");
        check_status("t7");

        // Randomised frames: geometry errors, enable, contents
        for (int k = 0; k < 12; k++) begin
            bit en;
            en      = ($urandom_range(0, 3) != 0);
            n_lines = $urandom_range(H - 1, H + 1);
            for (int r = 0; r < n_lines; r++) begin
                line_len[r] = ($urandom_range(0, 3) == 0) ? $urandom_range(W - 1, W + 1) : W;
                for (int c = 0; c < line_len[r]; c++) pix[r][c] = 8'($urandom_range(0, 255));
            end
            if (en) expect_frame(1'b0);
            send_frame(en, 1'b0, ($urandom_range(0, 1) == 1), 4);
            check_stream($sformatf("rnd%0d", k));
            check_status($sformatf("rnd%0d", k));
        end

        // Reset in the middle of the pixel phase, released with frame_valid high
        set_seq(8'h70, 1'b0);
        frame_valid = 1'b1;
        enable      = 1'b1;
        repeat (4) tick();
        line_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            pix_valid = 1'b1;
            pix_data  = pix[0][c];
            tick();
        end
        pix_valid = 1'b0;
        got_q.delete();
        reset_n = 1'b0;
        #1;
        check("t5_rst_dvalid", 32'(data_out_valid), 32'd0);
        check("t5_rst_busy",   32'(busy), 32'd0);
        check("t5_rst_count",  32'(frame_count), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        line_valid = 1'b0;
        tick();
        for (int r = 1; r < H; r++) begin
            line_valid = 1'b1;
            for (int c = 0; c < W; c++) begin
                pix_valid = 1'b1;
                pix_data  = pix[r][c];
                tick();
            end
            pix_valid  = 1'b0;
            line_valid = 1'b0;
            tick();
        end
        frame_valid = 1'b0;
        repeat (4) tick();
        exp_count = 8'd0;
        exp_err   = 1'b0;
        check_stream("t5");
        check_status("t5");
        set_seq(8'h80, 1'b0);
        expect_frame(1'b0);
        send_frame(1'b1, 1'b0, 1'b0, 4);
        check_stream("t5b");
        check_status("t5b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
